// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage sequencer: PC enable, pipeline stall/flush/freeze, debug step, perf counters
module fetch_controller #(
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter int         CW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_ex_mem_read,
  input  logic [4:0]    id_ex_rt,
  input  logic [4:0]    if_id_rs,
  input  logic [4:0]    if_id_rt,
  input  logic [5:0]    if_id_opcode,
  input  logic          branch_taken,
  input  logic          step_mode,
  input  logic          step_req,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic          ex_mem_flush,
  output logic          pipe_enable,
  output logic          halted,
  output logic          step_ack,
  output logic [CW-1:0] fetch_count,
  output logic [CW-1:0] stall_count
);

  typedef enum logic [2:0] {BOOT, RUN, REFILL, STEP_WAIT, HALT} state_t;

  state_t state, state_n;
  logic   step_req_q;
  logic   step_edge;
  logic   load_use;
  logic   stall_inc;
  logic   step_ack_n;

  assign step_edge = step_req && !step_req_q;
  assign load_use  = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                     ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  always_comb begin
    state_n      = state;
    pipe_enable  = 1'b1;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall_inc    = 1'b0;
    step_ack_n   = 1'b0;
    case (state)
      BOOT: begin
        pc_write     = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_n      = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          state_n      = REFILL;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (if_id_opcode == HALT_OPCODE) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          state_n     = HALT;
        end else if (step_mode) begin
          state_n    = STEP_WAIT;
          step_ack_n = 1'b1;
        end
      end
      REFILL: begin
        // MEM holds a bubble here, so a branch_taken now is not a real branch
        if_id_flush = 1'b1;
        state_n     = step_mode ? STEP_WAIT : RUN;
      end
      STEP_WAIT: begin
        pipe_enable = 1'b0;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if (step_edge || !step_mode) state_n = RUN;
      end
      HALT: begin
        pipe_enable = 1'b0;
        pc_write    = 1'b0;
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      step_req_q <= 1'b0;
      halted     <= 1'b0;
      step_ack   <= 1'b0;
    end else begin
      state      <= state_n;
      step_req_q <= step_req;
      halted     <= (state_n == HALT);
      step_ack   <= step_ack_n;
    end
  end

  // Both counters saturate at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (pc_write && pipe_enable && (fetch_count != '1))
        fetch_count <= fetch_count + CW'(1);
      if (stall_inc && (stall_count != '1))
        stall_count <= stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
  logic [5:0]  if_id_opcode;
  logic        branch_taken, step_mode, step_req;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic        pipe_enable, halted, step_ack;
  logic [15:0] fetch_count, stall_count;

  fetch_controller #(.HALT_OPCODE(6'h3F), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_opcode(if_id_opcode),
    .branch_taken(branch_taken), .step_mode(step_mode), .step_req(step_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pipe_enable(pipe_enable), .halted(halted), .step_ack(step_ack),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // comb = {pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
  typedef struct packed {
    logic       mr;
    logic [4:0] ert, rs, rt;
    logic [5:0] op;
    logic       br, sm, sr;
    logic [5:0] comb;
    logic       h, a, lu;
  } row_t;

  typedef struct packed {
    logic [5:0] comb;
    logic       h, a, lu;
  } exp_t;

  localparam logic [5:0] C_BOOT  = 6'b101111;
  localparam logic [5:0] C_RUN   = 6'b111000;
  localparam logic [5:0] C_STALL = 6'b100010;
  localparam logic [5:0] C_BR    = 6'b111111;
  localparam logic [5:0] C_REF   = 6'b111100;
  localparam logic [5:0] C_SW    = 6'b000000;
  localparam logic [5:0] C_HALT  = 6'b001000;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_fetch = '0;
  logic [15:0] exp_stall = '0;

  function automatic row_t mk(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [5:0] op, input logic br,
                              input logic sm, input logic sr, input logic [5:0] comb,
                              input logic h, input logic a, input logic lu);
    row_t r;
    r = '{mr, ert, rs, rt, op, br, sm, sr, comb, h, a, lu};
    return r;
  endfunction

  task automatic drive(input row_t r);
    id_ex_mem_read = r.mr;
    id_ex_rt       = r.ert;
    if_id_rs       = r.rs;
    if_id_rt       = r.rt;
    if_id_opcode   = r.op;
    branch_taken   = r.br;
    step_mode      = r.sm;
    step_req       = r.sr;
    sb.push_back('{r.comb, r.h, r.a, r.lu});
  endtask

  function automatic logic [39:0] obs();
    return {pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
            halted, step_ack, fetch_count, stall_count};
  endfunction

  function automatic logic [39:0] want(input exp_t e);
    return {e.comb, e.h, e.a, exp_fetch, exp_stall};
  endfunction

  // Counters observed in a cycle reflect only earlier cycles, so fold this one in afterwards
  task automatic account(input exp_t e);
    if (e.comb[5] && e.comb[4] && exp_fetch != 16'hFFFF) exp_fetch = exp_fetch + 16'd1;
    if (e.lu && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
  endtask

  task automatic test_reset();
    row_t r[$];
    exp_t e;
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_BOOT, 0, 0, 0));
    r.push_back(mk(1, 5, 5, 0, 6'h3F, 1, 1, 1, C_BOOT, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]); #1; e = sb.pop_front(); n_cmp++;
      if (obs() !== want(e)) begin
        n_fail++; $display("FAIL reset row %0d: got %h want %h", i, obs(), want(e));
      end
      account(e); @(negedge clk);
    end
  endtask

  task automatic test_run_straight();
    row_t r[$];
    exp_t e;
    reset = 1'b0;
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_BOOT, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      r.push_back(mk(0, 5'(k + 1), 5'(k + 2), 5'(k + 3), 6'(k), 0, 0, 0, C_RUN, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]); #1; e = sb.pop_front(); n_cmp++;
      if (obs() !== want(e)) begin
        n_fail++; $display("FAIL run_straight row %0d: got %h want %h", i, obs(), want(e));
      end
      account(e); @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    row_t r[$];
    exp_t e;
    r.push_back(mk(1, 5, 5, 0, 0, 0, 0, 0, C_STALL, 0, 0, 1));
    r.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0));
    r.push_back(mk(1, 7, 2, 7, 0, 0, 0, 0, C_STALL, 0, 0, 1));
    r.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0));
    r.push_back(mk(0, 5, 5, 5, 0, 0, 0, 0, C_RUN,   0, 0, 0));
    r.push_back(mk(1, 9, 8, 10, 0, 0, 0, 0, C_RUN,  0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]); #1; e = sb.pop_front(); n_cmp++;
      if (obs() !== want(e)) begin
        n_fail++; $display("FAIL load_use row %0d: got %h want %h", i, obs(), want(e));
      end
      account(e); @(negedge clk);
    end
  endtask

  task automatic test_branch();
    row_t r[$];
    exp_t e;
    r.push_back(mk(1, 5, 5, 0, 0, 1, 0, 0, C_BR,  0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, C_REF, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, C_BR,  0, 0, 0));
    r.push_back(mk(1, 4, 4, 0, 0, 0, 0, 0, C_REF, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]); #1; e = sb.pop_front(); n_cmp++;
      if (obs() !== want(e)) begin
        n_fail++; $display("FAIL branch row %0d: got %h want %h", i, obs(), want(e));
      end
      account(e); @(negedge clk);
    end
  endtask

  task automatic test_step();
    row_t r[$];
    exp_t e;
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_RUN, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_SW,  0, 1, 0));
    for (int p = 0; p < 3; p++) begin
      r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, C_SW,  0, 0, 0));
      r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 0, 0));
      r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, C_SW,  0, 1, 0));
      r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_SW,  0, 0, 0));
    end
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_SW,  0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]); #1; e = sb.pop_front(); n_cmp++;
      if (obs() !== want(e)) begin
        n_fail++; $display("FAIL step row %0d: got %h want %h", i, obs(), want(e));
      end
      account(e); @(negedge clk);
    end
  endtask

  task automatic test_halt();
    row_t r[$];
    exp_t e;
    r.push_back(mk(0, 0, 0, 0, 6'h3F, 1, 0, 0, C_BR,    0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, C_REF,   0, 0, 0));
    r.push_back(mk(1, 3, 3, 0, 6'h3F, 0, 0, 0, C_STALL, 0, 0, 1));
    r.push_back(mk(0, 0, 0, 0, 6'h3F, 0, 0, 0, C_STALL, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0,     1, 0, 0, C_HALT,  1, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0,     0, 1, 1, C_HALT,  1, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0,     0, 1, 0, C_HALT,  1, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, C_HALT,  1, 0, 0));
    foreach (r[i]) begin
      drive(r[i]); #1; e = sb.pop_front(); n_cmp++;
      if (obs() !== want(e)) begin
        n_fail++; $display("FAIL halt row %0d: got %h want %h", i, obs(), want(e));
      end
      account(e); @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    row_t r[$];
    exp_t e;
    reset = 1'b1;
    exp_fetch = '0;
    exp_stall = '0;
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_BOOT, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]); #1; e = sb.pop_front(); n_cmp++;
      if (obs() !== want(e)) begin
        n_fail++; $display("FAIL reset_mid row %0d: got %h want %h", i, obs(), want(e));
      end
      account(e); @(negedge clk);
    end
    reset = 1'b0;
    r.delete();
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_BOOT, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN,  0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN,  0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]); #1; e = sb.pop_front(); n_cmp++;
      if (obs() !== want(e)) begin
        n_fail++; $display("FAIL reboot row %0d: got %h want %h", i, obs(), want(e));
      end
      account(e); @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    id_ex_mem_read = 1'b0;
    id_ex_rt = '0;
    if_id_rs = '0;
    if_id_rt = '0;
    if_id_opcode = '0;
    branch_taken = 1'b0;
    step_mode = 1'b0;
    step_req = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_run_straight();
    test_load_use();
    test_branch();
    test_step();
    test_halt();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
